butterfly_serial_bridge: RTL
============================

// Module: butterfly_serial_bridge
// PURPOSE
//  Parametrised, self-framing serial bridge between a narrow pin-limited host link and the butterfly core.
//  Replaces manual shift/load/unload strobes with a counted-frame FSM: auto-issue, result wait with timeout, handshaked unload.
//  Sits between the TinyTapeout pin wrapper and the butterfly instance; host link width is SER_W bits per beat.
// PARAMETERS
//  COEF_W    24  coefficient width (aj, ajlen, zeta, bj, bjlen)
//  MODE_W    3   butterfly mode field width
//  SER_W     1   serial lanes per beat; legal values 1, 2, 4, 8
//  MAX_WAIT  64  cycles allowed in WAIT for bf_valido before timeout (>=2)
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst            in   1           reset; asynchronous assertion, active-high
//  frame_start    in   1           1-cycle pulse: open a new input frame
//  ser_in_valid   in   1           input beat present this cycle
//  ser_in_data    in   SER_W       input beat, MSB lane = earlier bit
//  ser_out_valid  out  1           output beat present
//  ser_out_ready  in   1           host accepts output beat
//  ser_out_data   out  SER_W       output beat
//  busy           out  1           state != IDLE
//  err_timeout    out  1           sticky until next frame_start accepted in IDLE
//  bf_mode        out  MODE_W      to core
//  bf_validi      out  1           to core, 1-cycle issue strobe
//  bf_aj/bf_ajlen/bf_zeta  out  COEF_W each, to core
//  bf_bj/bf_bjlen in   COEF_W each, from core
//  bf_valido      in   1           from core, result strobe
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, shift registers 0; rst mid-frame aborts immediately, no partial output.
//  Frames: IN_BITS=MODE_W+3*COEF_W (75), IN_BEATS=ceil(IN_BITS/SER_W); input frame {mode,aj,ajlen,zeta} MSB first,
//   pad bits at LSB end of last beat, discarded. OUT_BITS=1+2*COEF_W (49), OUT_BEATS=ceil(OUT_BITS/SER_W);
//   output frame {err,bj,bjlen} MSB first, pad bits in last beat driven 0.
//  FSM IDLE -> LOAD -> ISSUE -> WAIT -> UNLOAD -> IDLE.
//  IDLE: ser_in_valid ignored; frame_start -> LOAD, beat_cnt=0, err_timeout cleared.
//  LOAD: each ser_in_valid cycle shifts SER_W bits in, beat_cnt++; on beat IN_BEATS-1 accepted -> ISSUE next cycle.
//   frame_start in LOAD restarts: beat_cnt=0, prior beats discarded (frame_start wins over same-cycle ser_in_valid).
//  ISSUE: exactly one cycle bf_validi=1 with bf_* fields from frame; fields held stable until next ISSUE -> WAIT.
//  WAIT: wait_cnt++ each cycle; bf_valido=1 -> capture {0,bj,bjlen} -> UNLOAD. If wait_cnt reaches MAX_WAIT with no
//   valido -> capture {1,0,0}, err_timeout=1 -> UNLOAD. valido and timeout in same cycle: valido wins.
//  UNLOAD: ser_out_valid=1, ser_out_data=top beat; beat advances only on valid&&ready; data stable while ready=0.
//   Last beat accepted -> IDLE next cycle, ser_out_valid=0.
//  frame_start in ISSUE/WAIT/UNLOAD ignored; bf_valido outside WAIT ignored; ser_in_valid outside LOAD ignored.
//  Latency: ISSUE the cycle after last input beat; UNLOAD first beat the cycle after bf_valido.
// STRUCTURE
//  Shared include butterfly_defs.vh: COEF_W, MODE_W defaults, state encodings (3-bit), frame-width macros.
//  One sub-module: ser_shift_reg #(W,SER_W) - loadable shift register, SER_W-bit shift, parallel load/read;
//   instantiated twice (input SIPO, output PISO). FSM, counters, timeout in top.
//  beat_cnt width $clog2(max(IN_BEATS,OUT_BEATS)+1); wait_cnt width $clog2(MAX_WAIT+1).
// TESTING (stub core: fixed latency L, returns programmable bj/bjlen)
//  SER_W=1, frame mode=3'b001,aj=24'h000001,ajlen=24'h000002,zeta=24'h000003 -> ISSUE after 75th beat, one-cycle
//   bf_validi with those exact fields.
//  SER_W=4, L=3, stub bj=24'h123456,bjlen=24'hABCDEF -> 13 output beats reassembling {1'b0,24'h123456,24'hABCDEF},
//   last beat low 3 bits 0, first beat 1 cycle after valido.
//  Back-pressure: ready=0 for 5 cycles mid-unload -> ser_out_valid=1, data unchanged; no beat lost/duplicated.
//  Timeout: MAX_WAIT=16, stub never asserts valido -> UNLOAD after 16 WAIT cycles, frame {1,0,0}, err_timeout=1
//   until next frame_start.
//  Restart: frame_start after 10 LOAD beats, then full frame -> only second frame issued, exactly one bf_validi.
//  Async reset asserted mid-UNLOAD (between edges) -> all outputs 0 immediately, busy=0; next frame completes normally.

Source files
------------

// File: rtl/butterfly_serial_bridge_pkg.sv
// Shared constants for the butterfly serial bridge: default widths, FSM state codes, frame-size helpers.
package butterfly_serial_bridge_pkg;

  localparam int COEF_W_DEF = 24;
  localparam int MODE_W_DEF = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_UNLOAD = 3'd4;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/butterfly_serial_bridge_if.sv
// Host-side serial link of the butterfly bridge: framed input beats and handshaked output beats.
interface butterfly_serial_bridge_if #(
  parameter int SER_W = 1
);
  // Output beats transfer on every cycle where ser_out_valid && ser_out_ready;
  // ser_out_data is held stable while valid is high and ready is low.
  logic             frame_start;
  logic             ser_in_valid;
  logic [SER_W-1:0] ser_in_data;
  logic             ser_out_valid;
  logic             ser_out_ready;
  logic [SER_W-1:0] ser_out_data;

  modport master (
    output frame_start, ser_in_valid, ser_in_data, ser_out_ready,
    input  ser_out_valid, ser_out_data
  );

  modport slave (
    input  frame_start, ser_in_valid, ser_in_data, ser_out_ready,
    output ser_out_valid, ser_out_data
  );
endinterface

// File: rtl/butterfly_serial_bridge_ser_shift_reg.sv
// Loadable shift register moving SER_W bits per shift toward the MSB end; parallel load wins over shift.
module ser_shift_reg #(
  parameter int W     = 8,
  parameter int SER_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_en,
  input  logic [W-1:0]     load_data,
  input  logic             shift_en,
  input  logic [SER_W-1:0] shift_in,
  output logic [W-1:0]     data_o
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load_en) begin
      data_d = load_data;
    end else if (shift_en) begin
      data_d = {data_q[W-SER_W-1:0], shift_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/butterfly_serial_bridge.sv
// Self-framing serial bridge: collects an input frame, issues it to the butterfly core,
// waits for the result (with timeout) and streams the result frame back out.
module butterfly_serial_bridge
  import butterfly_serial_bridge_pkg::*;
#(
  parameter int COEF_W   = COEF_W_DEF,
  parameter int MODE_W   = MODE_W_DEF,
  parameter int SER_W    = 1,
  parameter int MAX_WAIT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  butterfly_serial_bridge_if.slave host,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [MODE_W-1:0]    bf_mode,
  output logic                 bf_validi,
  output logic [COEF_W-1:0]    bf_aj,
  output logic [COEF_W-1:0]    bf_ajlen,
  output logic [COEF_W-1:0]    bf_zeta,
  input  logic [COEF_W-1:0]    bf_bj,
  input  logic [COEF_W-1:0]    bf_bjlen,
  input  logic                 bf_valido,
  output logic [2:0]           dbg_state
);

  localparam int IN_BITS   = MODE_W + 3 * COEF_W;
  localparam int IN_BEATS  = ceil_div(IN_BITS, SER_W);
  localparam int IN_PAD    = IN_BEATS * SER_W;
  localparam int OUT_BITS  = 1 + 2 * COEF_W;
  localparam int OUT_BEATS = ceil_div(OUT_BITS, SER_W);
  localparam int OUT_PAD   = OUT_BEATS * SER_W;
  localparam int CNT_W     = $clog2(max2(IN_BEATS, OUT_BEATS) + 1);
  localparam int WAIT_W    = $clog2(MAX_WAIT + 1);

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                err_timeout_q, err_timeout_d;
  logic [IN_BITS-1:0]  fields_q, fields_d;

  logic                in_shift, out_load, out_shift;
  logic [OUT_BITS-1:0] out_word;
  logic [OUT_PAD-1:0]  out_load_data;
  logic [IN_PAD-1:0]   in_sr;
  logic [OUT_PAD-1:0]  out_sr;
  logic [IN_BITS-1:0]  frame_fields;

  // Pad bits sit below the frame in the input register, so the frame is its top IN_BITS.
  assign frame_fields  = IN_BITS'(in_sr >> (IN_PAD - IN_BITS));
  assign out_load_data = OUT_PAD'(out_word) << (OUT_PAD - OUT_BITS);

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    err_timeout_d = err_timeout_q;
    fields_d      = fields_q;
    in_shift      = 1'b0;
    out_load      = 1'b0;
    out_shift     = 1'b0;
    out_word      = '0;
    case (state_q)
      ST_IDLE: begin
        if (host.frame_start) begin
          state_d       = ST_LOAD;
          beat_cnt_d    = '0;
          err_timeout_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (host.frame_start) begin
          beat_cnt_d = '0;
        end else if (host.ser_in_valid) begin
          in_shift = 1'b1;
          if (beat_cnt_q == CNT_W'(IN_BEATS - 1)) begin
            state_d    = ST_ISSUE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        fields_d   = frame_fields;
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // A result arriving on the last allowed cycle beats the timeout.
        if (bf_valido) begin
          out_load   = 1'b1;
          out_word   = {1'b0, bf_bj, bf_bjlen};
          beat_cnt_d = '0;
          state_d    = ST_UNLOAD;
        end else if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
          out_load      = 1'b1;
          out_word      = {1'b1, {(2 * COEF_W){1'b0}}};
          err_timeout_d = 1'b1;
          beat_cnt_d    = '0;
          state_d       = ST_UNLOAD;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_UNLOAD: begin
        if (host.ser_out_ready) begin
          out_shift = 1'b1;
          if (beat_cnt_q == CNT_W'(OUT_BEATS - 1)) begin
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      beat_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
      fields_q      <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
      fields_q      <= fields_d;
    end
  end

  ser_shift_reg #(.W(IN_PAD), .SER_W(SER_W)) u_in_sipo (
    .clk       (clk),
    .rst       (rst),
    .load_en   (1'b0),
    .load_data ('0),
    .shift_en  (in_shift),
    .shift_in  (host.ser_in_data),
    .data_o    (in_sr)
  );

  ser_shift_reg #(.W(OUT_PAD), .SER_W(SER_W)) u_out_piso (
    .clk       (clk),
    .rst       (rst),
    .load_en   (out_load),
    .load_data (out_load_data),
    .shift_en  (out_shift),
    .shift_in  ('0),
    .data_o    (out_sr)
  );

  // During ISSUE the core sees the freshly assembled frame; afterwards the held copy.
  assign {bf_mode, bf_aj, bf_ajlen, bf_zeta} = (state_q == ST_ISSUE) ? frame_fields : fields_q;
  assign bf_validi          = (state_q == ST_ISSUE);
  assign host.ser_out_valid = (state_q == ST_UNLOAD);
  assign host.ser_out_data  = SER_W'(out_sr >> (OUT_PAD - SER_W));
  assign busy               = (state_q != ST_IDLE);
  assign err_timeout        = err_timeout_q;
  assign dbg_state          = state_q;

endmodule
